// File: rtl/mux_sweep_pkg.sv
// Shared types and helpers for the minterm MUX sweeper.
// Provides fold codes, FSM states, sizing constants and the fold function.
package mux_sweep_pkg;

    localparam int N_VARS  = 4;
    localparam int N_LINES = 8;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        P    = 2'd2,
        NP   = 2'd3
    } fold_code_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    // m0 is the minterm with P=0, m1 the one with P=1 for the same Q,R,S.
    function automatic fold_code_t fold(input logic m0, input logic m1);
        fold_code_t c;
        c = ZERO;
        unique case ({m1, m0})
            2'b00: c = ZERO;
            2'b11: c = ONE;
            2'b10: c = P;
            2'b01: c = NP;
            default: c = ZERO;
        endcase
        return c;
    endfunction

    function automatic logic apply_code(input fold_code_t c, input logic p);
        logic v;
        v = 1'b0;
        unique case (c)
            ZERO: v = 1'b0;
            ONE:  v = 1'b1;
            P:    v = p;
            NP:   v = ~p;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mux_input_folder.sv
// Folds a 16-bit minterm mask into 8 MUX data-line codes and levels.
// Ports: mask_i (latched mask), var_p_i (current P), mux_data_o (lines A..H).
module mux_input_folder
    import mux_sweep_pkg::*;
(
    input  logic [2*N_LINES-1:0] mask_i,
    input  logic                 var_p_i,
    output logic [N_LINES-1:0]   mux_data_o
);

    fold_code_t codes [N_LINES];

    always_comb begin
        for (int j = 0; j < N_LINES; j++) begin
            codes[j]      = fold(mask_i[j], mask_i[j+N_LINES]);
            mux_data_o[j] = apply_code(codes[j], var_p_i);
        end
    end

endmodule

// File: rtl/minterm_mux_sweeper.sv
// Sweeps F(P,Q,R,S) through an external 8:1 MUX and captures Y per minterm.
// Ports: clk, rst_n (sync, active-low), start, minterm_mask -> mux_sel,
//   mux_data, var_p to the MUX; mux_y back; busy, done, captured,
//   mismatch_cnt, err status. Define MSWEEP_SELFCHECK_EN to compare Y
//   against the mask; otherwise mismatch_cnt and err read 0.
module minterm_mux_sweeper
    import mux_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  minterm_mask,
    output logic [2:0]   mux_sel,
    output logic [7:0]   mux_data,
    output logic         var_p,
    input  logic         mux_y,
    output logic         busy,
    output logic         done,
    output logic [15:0]  captured,
    output logic [4:0]   mismatch_cnt,
    output logic         err
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         mask_q, mask_d;
    logic [15:0]         cap_q, cap_d;

`ifdef MSWEEP_SELFCHECK_EN
    logic [4:0]          mm_q, mm_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cap_d   = cap_q;
`ifdef MSWEEP_SELFCHECK_EN
        mm_d    = mm_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = minterm_mask;
                    cap_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = DRIVE;
`ifdef MSWEEP_SELFCHECK_EN
                    mm_d    = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    cap_d[idx_q] = mux_y;
`ifdef MSWEEP_SELFCHECK_EN
                    if (mux_y != mask_q[idx_q] && mm_q != 5'd16)
                        mm_d = mm_q + 5'd1;
`endif
                    if (idx_q == 4'hF) begin
                        state_d = DONE;
`ifdef MSWEEP_SELFCHECK_EN
                        // include the final capture's compare
                        err_d   = (mm_d != 5'd0);
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
`ifdef MSWEEP_SELFCHECK_EN
            mm_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
`ifdef MSWEEP_SELFCHECK_EN
            mm_q    <= mm_d;
            err_q   <= err_d;
`endif
        end
    end

    mux_input_folder u_folder (
        .mask_i     (mask_q),
        .var_p_i    (idx_q[3]),
        .mux_data_o (mux_data)
    );

    assign mux_sel  = idx_q[2:0];
    assign var_p    = idx_q[3];
    assign busy     = (state_q == DRIVE);
    assign done     = (state_q == DONE);
    assign captured = cap_q;

`ifdef MSWEEP_SELFCHECK_EN
    assign mismatch_cnt = mm_q;
    assign err          = err_q;
`else
    assign mismatch_cnt = 5'd0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_minterm_mux_sweeper.sv
// Directed bench for minterm_mux_sweeper with an ideal 8:1 MUX model.
// Expected sweep results are queued at start and checked at done.
module tb_minterm_mux_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] minterm_mask = 16'h0;
    logic [2:0]  mux_sel;
    logic [7:0]  mux_data;
    logic        var_p;
    logic        mux_y;
    logic        busy;
    logic        done;
    logic [15:0] captured;
    logic [4:0]  mismatch_cnt;
    logic        err;
    logic        y_force0 = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] cap;
        logic [4:0]  mm;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // ideal 8:1 MUX, optionally stuck at 0
    assign mux_y = y_force0 ? 1'b0 : mux_data[mux_sel];

    minterm_mux_sweeper #(.SETTLE(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .minterm_mask (minterm_mask),
        .mux_sel      (mux_sel),
        .mux_data     (mux_data),
        .var_p        (var_p),
        .mux_y        (mux_y),
        .busy         (busy),
        .done         (done),
        .captured     (captured),
        .mismatch_cnt (mismatch_cnt),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shannon expansion on P: line j carries F(P,j) directly.
    function automatic logic [7:0] lines_for(input logic [15:0] m,
                                             input logic p);
        return p ? m[15:8] : m[7:0];
    endfunction

    task automatic reset_checks(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_cap"}, 32'(captured), 32'd0);
        check({pfx, "_mm"}, 32'(mismatch_cnt), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
        check({pfx, "_sel"}, 32'({var_p, mux_sel}), 32'd0);
        check({pfx, "_data"}, 32'(mux_data), 32'd0);
    endtask

    task automatic sweep(input logic [15:0] mask, input bit y0,
                         input int abort_t, input bit rep,
                         input logic [15:0] alt);
        exp_t e;
        logic [3:0] idx;
        e.cap = y0 ? 16'h0 : mask;
`ifdef MSWEEP_SELFCHECK_EN
        e.mm  = y0 ? 5'($countones(mask)) : 5'd0;
        e.err = (e.mm != 5'd0);
`else
        e.mm  = 5'd0;
        e.err = 1'b0;
`endif
        @(negedge clk);
        minterm_mask = mask;
        y_force0 = y0;
        start = 1'b1;
        if (abort_t < 0) sb.push_back(e);
        for (int t = 1; t <= 34; t++) begin
            @(negedge clk);
            if (t == 1) begin
                start = 1'b0;
                check("start_cap_clr", 32'(captured), 32'd0);
                check("start_mm_clr", 32'(mismatch_cnt), 32'd0);
                check("start_err_clr", 32'(err), 32'd0);
            end
            if (rep && (t == 10 || t == 33)) begin
                minterm_mask = alt;
                start = 1'b1;
            end
            if (rep && (t == 11 || t == 34)) start = 1'b0;
            check("busy", 32'(busy), 32'(t <= 32));
            check("done", 32'(done), 32'(t == 33));
            if (t <= 32) begin
                idx = 4'((t - 1) / 2);
                check("step_idx", 32'({var_p, mux_sel}), 32'(idx));
                check("mux_data", 32'(mux_data),
                      32'(lines_for(mask, idx[3])));
            end
            if (t == 33) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("captured", 32'(captured), 32'(e.cap));
                    check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mm));
                    check("err", 32'(err), 32'(e.err));
                end
            end
            if (t == abort_t) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                reset_checks("abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done), 32'd0);
                    check("abort_idle", 32'(busy), 32'd0);
                end
                y_force0 = 1'b0;
                return;
            end
        end
        if (rep) begin
            @(negedge clk);
            check("late_start_ignored", 32'(busy), 32'd0);
            check("single_done", 32'(done), 32'd0);
        end
        y_force0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("rst");
        rst_n = 1'b1;

        sweep(16'h4D4A, 1'b0, -1, 1'b0, 16'h0);
        sweep(16'h0000, 1'b0, -1, 1'b0, 16'h0);
        sweep(16'hFFFF, 1'b0, -1, 1'b0, 16'h0);
        sweep(16'h4D4A, 1'b1, -1, 1'b0, 16'h0);
        sweep(16'h4D4A, 1'b0, -1, 1'b0, 16'h0);
        sweep(16'h1234, 1'b0, 19, 1'b0, 16'h0);
        sweep(16'h1234, 1'b0, -1, 1'b0, 16'h0);
        sweep(16'h4D4A, 1'b0, -1, 1'b1, 16'hB2B5);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
